// File: rtl/generador_sincronia_vga.sv
// VGA timing generator: pixel-clock divider plus horizontal/vertical counters,
// with registered hsync, vsync, visible-area flag, coordinates and pulses.
`timescale 1ns/1ps
module generador_sincronia_vga #(
  parameter int   TICKS_POR_PIXEL = 2,
  parameter int   H_VISIBLE       = 640,
  parameter int   H_FRONT         = 16,
  parameter int   H_SYNC          = 96,
  parameter int   H_BACK          = 48,
  parameter int   V_VISIBLE       = 480,
  parameter int   V_FRONT         = 10,
  parameter int   V_SYNC          = 2,
  parameter int   V_BACK          = 33,
  parameter logic SYNC_POL        = 1'b0,
  parameter int   CNT_W           = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             pixel_tick,
  output logic             fin_cuadro
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (TICKS_POR_PIXEL > 1) ? $clog2(TICKS_POR_PIXEL) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(TICKS_POR_PIXEL - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic             SYNC_ON      = SYNC_POL;
  localparam logic             SYNC_OFF     = ~SYNC_POL;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic [CNT_W-1:0] r_pixel_x;
  logic [CNT_W-1:0] r_pixel_y;
  logic             r_pixel_tick;
  logic             r_fin_cuadro;

  logic             w_div_last;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_hsync_act;
  logic             w_vsync_act;
  logic             w_visible;
  logic [DIV_W-1:0] w_div_next;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;

  assign w_div_last  = (r_div == DIV_LAST);
  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_hsync_act = (r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END);
  assign w_vsync_act = (r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END);
  assign w_visible   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_div_next = r_div + 1'b1;
    w_h_next   = r_h_cnt;
    w_v_next   = r_v_cnt;
    if (w_div_last) begin
      w_div_next = '0;
      w_h_next   = r_h_cnt + 1'b1;
      if (w_h_last) begin
        w_h_next = '0;
        w_v_next = w_v_last ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (enable) begin
      r_div   <= w_div_next;
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  // Decoded outputs hold while stalled; only the pulses are forced low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync      <= SYNC_OFF;
      r_vsync      <= SYNC_OFF;
      r_video_on   <= 1'b0;
      r_pixel_x    <= '0;
      r_pixel_y    <= '0;
      r_pixel_tick <= 1'b0;
      r_fin_cuadro <= 1'b0;
    end else begin
      r_pixel_tick <= enable && w_div_last;
      r_fin_cuadro <= enable && w_div_last && w_h_last && w_v_last;
      if (enable) begin
        r_hsync    <= w_hsync_act ? SYNC_ON : SYNC_OFF;
        r_vsync    <= w_vsync_act ? SYNC_ON : SYNC_OFF;
        r_video_on <= w_visible;
        r_pixel_x  <= r_h_cnt;
        r_pixel_y  <= r_v_cnt;
      end
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = r_video_on;
  assign pixel_x    = r_pixel_x;
  assign pixel_y    = r_pixel_y;
  assign pixel_tick = r_pixel_tick;
  assign fin_cuadro = r_fin_cuadro;

endmodule

// File: tb/tb_generador_sincronia_vga.sv
// Directed bench for generador_sincronia_vga: default 640x480 timing plus two
// small configurations for whole-frame, vsync, stall and async-reset behaviour.
`timescale 1ns/1ps
module tb_generador_sincronia_vga;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;
  bit   clk_run = 1'b1;

  logic        hs_a, vs_a, vid_a, tick_a, fin_a;
  logic [10:0] x_a, y_a;
  logic        hs_b, vs_b, vid_b, tick_b, fin_b;
  logic [4:0]  x_b, y_b;
  logic        hs_c, vs_c, vid_c, tick_c, fin_c;
  logic [3:0]  x_c, y_c;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int q_hs_a[$], q_hs_b[$], q_vs_b[$], q_fin_b[$], q_hs_c[$], q_vs_c[$], q_fin_c[$];
  logic p_hs_a, p_hs_b, p_vs_b, p_hs_c, p_vs_c;

  // Default 640x480@60 timing.
  generador_sincronia_vga dut_a (
    .clk(clk), .reset(rst), .enable(en_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vid_a),
    .pixel_x(x_a), .pixel_y(y_a), .pixel_tick(tick_a), .fin_cuadro(fin_a)
  );

  // One clock per pixel, 14x7 frame = 98 clks.
  generador_sincronia_vga #(
    .TICKS_POR_PIXEL(1),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .CNT_W(5)
  ) dut_b (
    .clk(clk), .reset(rst), .enable(en_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
    .pixel_x(x_b), .pixel_y(y_b), .pixel_tick(tick_b), .fin_cuadro(fin_b)
  );

  // Three clocks per pixel, 8x7 frame = 168 clks, active-high sync.
  generador_sincronia_vga #(
    .TICKS_POR_PIXEL(3),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) dut_c (
    .clk(clk), .reset(rst), .enable(en_c),
    .hsync(hs_c), .vsync(vs_c), .video_on(vid_c),
    .pixel_x(x_c), .pixel_y(y_c), .pixel_tick(tick_c), .fin_cuadro(fin_c)
  );

  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap_prev();
    p_hs_a = hs_a; p_hs_b = hs_b; p_vs_b = vs_b; p_hs_c = hs_c; p_vs_c = vs_c;
  endtask

  task automatic clear_logs();
    q_hs_a.delete(); q_hs_b.delete(); q_vs_b.delete(); q_fin_b.delete();
    q_hs_c.delete(); q_vs_c.delete(); q_fin_c.delete();
  endtask

  // One clock edge, sampled 1 ns later; logs the cycle of every sync transition and frame pulse.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (hs_a !== p_hs_a && q_hs_a.size() < 8) q_hs_a.push_back(cyc);
    if (hs_b !== p_hs_b && q_hs_b.size() < 8) q_hs_b.push_back(cyc);
    if (vs_b !== p_vs_b && q_vs_b.size() < 8) q_vs_b.push_back(cyc);
    if (hs_c !== p_hs_c && q_hs_c.size() < 8) q_hs_c.push_back(cyc);
    if (vs_c !== p_vs_c && q_vs_c.size() < 8) q_vs_c.push_back(cyc);
    if (fin_b === 1'b1 && q_fin_b.size() < 8) q_fin_b.push_back(cyc);
    if (fin_c === 1'b1 && q_fin_c.size() < 8) q_fin_c.push_back(cyc);
    snap_prev();
  endtask

  initial begin
    int vid_cnt_a, tick_cnt_a, xstep_err_a, vs_low_a;
    int tick_cnt_b, vid_cnt_b, vid_cnt_c, stall_err_c, fin_cnt_b;
    int hold_err_a, stall_tick_a;
    logic [10:0] prev_x_a;
    logic        s_hs, s_vs, s_vid;
    logic [10:0] s_x, s_y;

    vid_cnt_a = 0; tick_cnt_a = 0; xstep_err_a = 0; vs_low_a = 0;
    tick_cnt_b = 0; vid_cnt_b = 0; vid_cnt_c = 0; stall_err_c = 0; fin_cnt_b = 0;
    hold_err_a = 0; stall_tick_a = 0;

    // Reset with the clock running.
    repeat (3) step();
    check("rst_hsync_a", hs_a, 1);
    check("rst_vsync_a", vs_a, 1);
    check("rst_video_a", vid_a, 0);
    check("rst_x_a", x_a, 0);
    check("rst_y_a", y_a, 0);
    check("rst_tick_a", tick_a, 0);
    check("rst_fin_a", fin_a, 0);
    check("rst_hsync_c_pol1", hs_c, 0);

    rst = 1'b0;
    cyc = 0;
    clear_logs();
    snap_prev();
    prev_x_a = x_a;

    // Run until the default generator shows pixel (300,10); dut_c stalls on edges 400..499.
    for (int i = 0; i < 20000 && !(x_a == 11'd300 && y_a == 11'd10); i++) begin
      en_c = !(cyc >= 399 && cyc <= 498);
      step();
      if (cyc == 1) begin
        check("first_video_a", vid_a, 1);
        check("first_x_a", x_a, 0);
        check("first_y_a", y_a, 0);
        check("first_tick_a", tick_a, 0);
      end
      if (cyc <= 1600) begin
        vid_cnt_a  += int'(vid_a);
        tick_cnt_a += int'(tick_a);
      end
      if (cyc == 1600) check("x_end_line0_a", x_a, 799);
      if (cyc == 1601) begin
        check("x_wrap_a", x_a, 0);
        check("y_line1_a", y_a, 1);
      end
      if (x_a != prev_x_a && x_a != ((prev_x_a == 11'd799) ? 11'd0 : prev_x_a + 11'd1))
        xstep_err_a++;
      prev_x_a = x_a;
      if (vs_a !== 1'b1) vs_low_a++;
      if (cyc <= 200) tick_cnt_b += int'(tick_b);
      if (cyc <= 98)  vid_cnt_b  += int'(vid_b);
      if (cyc <= 168) vid_cnt_c  += int'(vid_c);
      if (cyc >= 400 && cyc <= 499 && (tick_c !== 1'b0 || fin_c !== 1'b0 || x_c !== 4'd4))
        stall_err_c++;
      if (cyc == 500) check("resume_x_c", x_c, 5);
    end
    en_c = 1'b1;

    check("reach_300_10_cycle_a", cyc, 16601);
    check("video_clks_line0_a", vid_cnt_a, 1280);
    check("ticks_line0_a", tick_cnt_a, 800);
    check("x_step_errors_a", xstep_err_a, 0);
    check("vsync_inactive_top_a", vs_low_a, 0);
    check("hsync_fall_a", q_hs_a[0], 1313);
    check("hsync_rise_a", q_hs_a[1], 1505);
    check("hsync_fall2_a", q_hs_a[2], 2913);

    check("ticks_b", tick_cnt_b, 200);
    check("video_clks_frame_b", vid_cnt_b, 32);
    check("hsync_fall_b", q_hs_b[0], 11);
    check("hsync_rise_b", q_hs_b[1], 13);
    check("hsync_fall2_b", q_hs_b[2], 25);
    check("vsync_fall_b", q_vs_b[0], 71);
    check("vsync_rise_b", q_vs_b[1], 85);
    check("vsync_fall2_b", q_vs_b[2], 169);
    check("fin1_b", q_fin_b[0], 98);
    check("fin2_b", q_fin_b[1], 196);
    check("fin3_b", q_fin_b[2], 294);

    check("video_clks_frame_c", vid_cnt_c, 36);
    check("hsync_rise_c", q_hs_c[0], 16);
    check("hsync_fall_c", q_hs_c[1], 22);
    check("hsync_rise2_c", q_hs_c[2], 40);
    check("vsync_rise_c", q_vs_c[0], 97);
    check("vsync_fall_c", q_vs_c[1], 145);
    check("vsync_rise2_c", q_vs_c[2], 265);
    check("fin1_c", q_fin_c[0], 168);
    check("fin2_c", q_fin_c[1], 336);
    check("fin3_stalled_c", q_fin_c[2], 604);
    check("fin4_stalled_c", q_fin_c[3], 772);
    check("stall_hold_errors_c", stall_err_c, 0);

    // Stall the default generator for 100 clks at (300,10).
    en_a = 1'b0;
    s_hs = hs_a; s_vs = vs_a; s_vid = vid_a; s_x = x_a; s_y = y_a;
    repeat (100) begin
      step();
      if (hs_a !== s_hs || vs_a !== s_vs || vid_a !== s_vid || x_a !== s_x || y_a !== s_y)
        hold_err_a++;
      if (tick_a !== 1'b0 || fin_a !== 1'b0) stall_tick_a++;
    end
    check("stall_hold_errors_a", hold_err_a, 0);
    check("stall_pulses_a", stall_tick_a, 0);
    en_a = 1'b1;
    step();
    check("resume_x300_a", x_a, 300);
    check("resume_tick_a", tick_a, 1);
    step();
    check("resume_x301_a", x_a, 301);
    check("resume_y_a", y_a, 10);

    // Asynchronous reset mid-frame with the clock stopped low.
    @(negedge clk);
    clk_run = 1'b0;
    #7;
    check("pre_rst_x_a", x_a, 301);
    rst = 1'b1;
    #3;
    check("async_hsync_a", hs_a, 1);
    check("async_vsync_a", vs_a, 1);
    check("async_video_a", vid_a, 0);
    check("async_x_a", x_a, 0);
    check("async_y_a", y_a, 0);
    check("async_tick_a", tick_a, 0);
    check("async_hsync_c", hs_c, 0);
    check("async_x_b", x_b, 0);
    #3;
    rst = 1'b0;
    #2;
    cyc = 0;
    clear_logs();
    snap_prev();
    clk_run = 1'b1;
    repeat (200) begin
      step();
      if (cyc == 1) begin
        check("post_rst_video_a", vid_a, 1);
        check("post_rst_x_a", x_a, 0);
        check("post_rst_y_a", y_a, 0);
      end
      fin_cnt_b += int'(fin_b);
    end
    check("post_rst_fin1_b", q_fin_b[0], 98);
    check("post_rst_fin2_b", q_fin_b[1], 196);
    check("post_rst_fin_count_b", fin_cnt_b, 2);
    check("post_rst_fin1_c", q_fin_c[0], 168);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
